// File: rtl/voice_mixer.sv
// Time-multiplexed 4-voice mixer: sums one signed channel sample per cycle,
// then scales by a 4-bit master volume into a 17-bit pre-clip result.
module voice_mixer #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 16
) (
  input  logic                   iClk,
  input  logic                   iResetN,
  input  logic                   iStart,
  input  logic [3:0]             iVolume,
  output logic [1:0]             oChSel,
  input  logic signed [CH_W-1:0] iChSample,
  output logic signed [16:0]     oMix,
  output logic                   oValid,
  output logic                   oBusy
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DONE} state_t;

  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  state_t             state_q, state_d;
  logic signed [17:0] acc_q, acc_d;
  logic [3:0]         vol_q, vol_d;
  logic [1:0]         ch_q, ch_d;
  logic signed [16:0] mix_q, mix_d;
  logic signed [22:0] prod;
  logic signed [16:0] res;

  // Volume is zero-extended so the product stays signed; >>> floors toward -inf.
  assign prod = 23'(acc_q) * 23'($signed({1'b0, vol_q}));
  assign res  = 17'(prod >>> 5);

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      state_q <= IDLE;
      acc_q   <= '0;
      vol_q   <= '0;
      ch_q    <= '0;
      mix_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      vol_q   <= vol_d;
      ch_q    <= ch_d;
      mix_q   <= mix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    vol_d   = vol_q;
    ch_d    = ch_q;
    mix_d   = mix_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          vol_d   = iVolume;
          acc_d   = '0;
          ch_d    = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + 18'(iChSample);
        if (ch_q == LAST_CH) begin
          ch_d    = '0;
          state_d = SCALE;
        end else begin
          ch_d = ch_q + 2'd1;
        end
      end
      SCALE: begin
        mix_d   = res;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign oChSel = ch_q;
  assign oMix   = mix_q;
  assign oValid = (state_q == DONE);
  assign oBusy  = (state_q != IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: directed table, randomized frames against an
// arithmetic reference, and reset/abort sequences.
module tb_voice_mixer;

  localparam int NUM_CH = 4;

  logic               iClk = 1'b0;
  logic               iResetN;
  logic               iStart;
  logic [3:0]         iVolume;
  logic [1:0]         oChSel;
  logic signed [15:0] iChSample;
  logic signed [16:0] oMix;
  logic               oValid;
  logic               oBusy;

  logic signed [15:0] smp [4];

  int checks = 0;
  int errors = 0;

  voice_mixer #(.NUM_CH(NUM_CH), .CH_W(16)) dut (
    .iClk      (iClk),
    .iResetN   (iResetN),
    .iStart    (iStart),
    .iVolume   (iVolume),
    .oChSel    (oChSel),
    .iChSample (iChSample),
    .oMix      (oMix),
    .oValid    (oValid),
    .oBusy     (oBusy)
  );

  always #5 iClk = ~iClk;

  // Upstream mux: sample follows the requested index combinationally.
  always_comb iChSample = smp[oChSel];

  typedef struct {
    int         s0, s1, s2, s3;
    logic [3:0] vol;
    int         mix;
    int         clip;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer sum, scale, floor-divide by 32.
  function automatic int model(input int vol);
    int sum, p;
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) sum += int'(smp[i]);
    p = sum * vol;
    return (p >= 0) ? p / 32 : -((-p + 31) / 32);
  endfunction

  // Downstream 17->16 clipper.
  function automatic int clip16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // One full frame; also pokes iStart and iVolume mid-frame to prove they are ignored.
  task automatic run_frame(input logic [3:0] vol, input int exp, input string name);
    int cyc;
    bit got;
    @(negedge iClk);
    iVolume = vol;
    iStart  = 1'b1;
    @(posedge iClk);
    #1;
    iStart  = 1'b0;
    iVolume = ~vol;
    got = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge iClk);
      iStart = (cyc == 2);
      if (oValid) begin
        got = 1'b1;
        break;
      end
      if (cyc <= NUM_CH) chk({name, " chsel"}, oChSel, cyc - 1);
      else               chk({name, " chsel idle"}, oChSel, 0);
      chk({name, " busy"}, oBusy, 1);
    end
    iStart = 1'b0;
    chk({name, " latency"}, got ? cyc : -1, NUM_CH + 2);
    chk({name, " mix"}, oMix, exp);
    chk({name, " busy@valid"}, oBusy, 1);
    @(negedge iClk);
    chk({name, " valid pulse"}, oValid, 0);
    chk({name, " busy end"}, oBusy, 0);
    chk({name, " mix hold"}, oMix, exp);
  endtask

  initial begin
    int nval;
    logic [3:0] v;

    tbl[0] = '{32767, 32767, 32767, 32767, 4'd15, 61438, 32767};
    tbl[1] = '{-32768, -32768, -32768, -32768, 4'd15, -61440, -32768};
    tbl[2] = '{1, 0, 0, 0, 4'd1, 0, 0};
    tbl[3] = '{-1, 0, 0, 0, 4'd1, -1, -1};
    tbl[4] = '{1234, -555, 32000, -7, 4'd0, 0, 0};
    tbl[5] = '{1000, -3000, 500, 0, 4'd8, -375, -375};

    for (int i = 0; i < 4; i++) smp[i] = '0;
    iResetN = 1'b0;
    iStart  = 1'b0;
    iVolume = 4'd0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("reset mix", oMix, 0);
    chk("reset valid", oValid, 0);
    chk("reset busy", oBusy, 0);
    chk("reset chsel", oChSel, 0);
    iResetN = 1'b1;
    @(negedge iClk);
    chk("post-reset busy", oBusy, 0);

    for (int i = 0; i < 6; i++) begin
      smp[0] = 16'(tbl[i].s0);
      smp[1] = 16'(tbl[i].s1);
      smp[2] = 16'(tbl[i].s2);
      smp[3] = 16'(tbl[i].s3);
      run_frame(tbl[i].vol, tbl[i].mix, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d clip", i), clip16(int'(oMix)), tbl[i].clip);
    end

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0:       smp[i] = 16'sh7fff;
          1:       smp[i] = 16'sh8000;
          default: smp[i] = 16'($urandom);
        endcase
      end
      v = 4'($urandom_range(0, 15));
      run_frame(v, model(int'(v)), $sformatf("rand%0d", n));
    end

    // Leave a nonzero oMix, then abort a frame during its SCALE cycle.
    for (int i = 0; i < 4; i++) smp[i] = 16'sd20000;
    run_frame(4'd15, model(15), "pre-abort");
    for (int i = 0; i < 4; i++) smp[i] = -16'sd12345;
    @(negedge iClk);
    iVolume = 4'd9;
    iStart  = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    repeat (NUM_CH + 1) @(negedge iClk);
    chk("abort in-frame busy", oBusy, 1);
    iResetN = 1'b0;
    #1;
    chk("abort mix", oMix, 0);
    chk("abort busy", oBusy, 0);
    chk("abort valid", oValid, 0);
    chk("abort chsel", oChSel, 0);
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iResetN = 1'b1;
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge iClk);
      if (oValid) nval++;
    end
    chk("abort no valid", nval, 0);
    chk("abort mix stays", oMix, 0);
    run_frame(4'd9, model(9), "after-abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
